// File: rtl/mac_array_acc.sv
// mac_array_acc: TIN-lane dot product (per-lane multiply, fully pipelined
// adder tree) accumulated over first/last delimited groups, emitting one
// saturated signed result per group.
module mac_array_acc #(
    parameter int TIN      = 16,
    parameter int LOG2_TIN = 4,
    parameter int DW       = 8,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_vld,
    input  logic                i_first,
    input  logic                i_last,
    input  logic                i_signed,
    input  logic [DW*TIN-1:0]   i_dat,
    input  logic [DW*TIN-1:0]   i_wt,
    output logic                o_vld,
    output logic [OUT_W-1:0]    o_dat,
    output logic                o_sat
);

    // Product width: (DW+1)-bit activation times DW-bit signed weight.
    localparam int PW = 2*DW + 1;
    // Tree nodes all use the root width so no level ever truncates.
    localparam int TW = PW + LOG2_TIN;
    // Sideband stages: index 0 = stage M, 1..LOG2_TIN = tree levels.
    localparam int NS = LOG2_TIN + 1;

    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                in_vld_reg;
    logic                in_first_reg;
    logic                in_last_reg;
    logic                in_signed_reg;
    logic [DW*TIN-1:0]   in_dat_reg;
    logic [DW*TIN-1:0]   in_wt_reg;

    logic [PW-1:0]       prod [TIN];
    // Heap-ordered tree: leaves at TIN..2*TIN-1, root at 1.
    logic [TW-1:0]       node_reg [1:2*TIN-1];

    logic [NS-1:0]       vld_pipe;
    logic [NS-1:0]       first_pipe;
    logic [NS-1:0]       last_pipe;

    logic [ACC_W-1:0]    acc_reg;
    logic                open_reg;

    logic [ACC_W-1:0]    tree_sum;
    logic [ACC_W-1:0]    acc_next;
    logic                sat_hi;
    logic                sat_lo;
    logic [OUT_W-1:0]    clamped;

    // Input sampling register: the beat is captured on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vld_reg    <= 1'b0;
            in_first_reg  <= 1'b0;
            in_last_reg   <= 1'b0;
            in_signed_reg <= 1'b0;
            in_dat_reg    <= '0;
            in_wt_reg     <= '0;
        end else begin
            in_vld_reg    <= i_vld;
            in_first_reg  <= i_first & i_vld;
            in_last_reg   <= i_last & i_vld;
            in_signed_reg <= i_signed;
            in_dat_reg    <= i_dat;
            in_wt_reg     <= i_wt;
        end
    end

    // Per-lane multiply: both operands are extended to the product width so
    // the low PW bits of the product are the exact two's complement result.
    genvar gi;
    generate
        for (gi = 0; gi < TIN; gi++) begin : g_lane
            logic [DW-1:0] act;
            logic [DW-1:0] wt;
            logic [PW-1:0] act_ext;
            logic [PW-1:0] wt_ext;
            assign act     = in_dat_reg[gi*DW +: DW];
            assign wt      = in_wt_reg[gi*DW +: DW];
            assign act_ext = {{(DW+1){in_signed_reg & act[DW-1]}}, act};
            assign wt_ext  = {{(DW+1){wt[DW-1]}}, wt};
            assign prod[gi] = act_ext * wt_ext;
        end
    endgenerate

    // Stage M registers the leaves; each internal node adds its children's
    // previous-cycle values, giving one registered level per tree stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 1; n < 2*TIN; n++) begin
                node_reg[n] <= '0;
            end
        end else begin
            for (int k = 0; k < TIN; k++) begin
                node_reg[TIN+k] <= TW'($signed(prod[k]));
            end
            for (int n = 1; n < TIN; n++) begin
                node_reg[n] <= node_reg[2*n] + node_reg[2*n+1];
            end
        end
    end

    // Sideband shift registers matching the multiply + tree latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[NS-2:0], in_vld_reg};
            first_pipe <= {first_pipe[NS-2:0], in_first_reg};
            last_pipe  <= {last_pipe[NS-2:0], in_last_reg};
        end
    end

    // Accumulator update value and output clamp.
    always_comb begin
        tree_sum = ACC_W'($signed(node_reg[1]));
        acc_next = tree_sum;
        if (!(first_pipe[NS-1] || !open_reg)) begin
            acc_next = acc_reg + tree_sum;
        end
        sat_hi  = $signed(acc_next) > $signed(SAT_MAX);
        sat_lo  = $signed(acc_next) < $signed(SAT_MIN);
        clamped = acc_next[OUT_W-1:0];
        if (sat_hi) begin
            clamped = OUT_MAX;
        end else if (sat_lo) begin
            clamped = OUT_MIN;
        end
    end

    // Accumulator and group-open flag; a last beat leaves no group open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            open_reg <= 1'b0;
        end else if (vld_pipe[NS-1]) begin
            acc_reg  <= acc_next;
            open_reg <= !last_pipe[NS-1];
        end
    end

    // Output register: loads on a closing beat, otherwise holds data/flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_dat <= '0;
            o_sat <= 1'b0;
        end else begin
            o_vld <= vld_pipe[NS-1] & last_pipe[NS-1];
            if (vld_pipe[NS-1] && last_pipe[NS-1]) begin
                o_dat <= clamped;
                o_sat <= sat_hi | sat_lo;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_acc.sv
// Directed testbench for mac_array_acc with TIN=4, DW=8, ACC_W=20, OUT_W=16.
module tb_mac_array_acc;

    localparam int TIN      = 4;
    localparam int LOG2_TIN = 2;
    localparam int DW       = 8;
    localparam int ACC_W    = 20;
    localparam int OUT_W    = 16;
    // Beat driven in cycle c is sampled on the next edge; result 4 edges later.
    localparam int LAT      = LOG2_TIN + 3;

    logic                clk;
    logic                rst;
    logic                i_vld;
    logic                i_first;
    logic                i_last;
    logic                i_signed;
    logic [DW*TIN-1:0]   i_dat;
    logic [DW*TIN-1:0]   i_wt;
    logic                o_vld;
    logic [OUT_W-1:0]    o_dat;
    logic                o_sat;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    int exp_cyc [$];
    int exp_dat [$];
    int exp_sat [$];

    mac_array_acc #(
        .TIN(TIN), .LOG2_TIN(LOG2_TIN), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_first(i_first), .i_last(i_last),
        .i_signed(i_signed), .i_dat(i_dat), .i_wt(i_wt),
        .o_vld(o_vld), .o_dat(o_dat), .o_sat(o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one beat for one cycle; a closing beat queues its expected result.
    task automatic beat(input logic f, input logic l, input logic s,
                        input logic [31:0] d, input logic [31:0] w,
                        input int exp_d, input int exp_s);
        i_vld    = 1'b1;
        i_first  = f;
        i_last   = l;
        i_signed = s;
        i_dat    = d;
        i_wt     = w;
        if (l) begin
            exp_cyc.push_back(cyc + LAT);
            exp_dat.push_back(exp_d);
            exp_sat.push_back(exp_s);
        end
        tick();
        i_vld   = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
    endtask

    // Output monitor: every o_vld pulse must match the next queued result.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_vld_low", int'(o_vld), 0);
        end else if (o_vld) begin
            if (exp_cyc.size() == 0) begin
                chk("spurious_vld", 1, 0);
            end else begin
                chk("out_cycle", cyc, exp_cyc.pop_front());
                chk("out_dat", int'($signed(o_dat)), exp_dat.pop_front());
                chk("out_sat", int'(o_sat), exp_sat.pop_front());
            end
        end
    end

    logic [7:0]  lane_b;
    logic [31:0] bb_dat;

    initial begin
        rst = 1'b1; i_vld = 1'b0; i_first = 1'b0; i_last = 1'b0;
        i_signed = 1'b0; i_dat = '0; i_wt = '0;
        idle(2);
        rst = 1'b0;
        chk("reset_vld", int'(o_vld), 0);
        chk("reset_dat", int'(o_dat), 0);
        chk("reset_sat", int'(o_sat), 0);
        idle(2);

        // Single-beat group: 1+2+3+4 = 10.
        beat(1, 1, 1, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h01010101, 10, 0);
        idle(6);

        // Saturation high (4 * 16384 = 65536) then low (4 * -16256 = -65024).
        beat(1, 1, 1, 32'h80808080, 32'h80808080, 32767, 1);
        beat(1, 1, 1, 32'h80808080, 32'h7F7F7F7F, -32768, 1);
        idle(6);

        // Signedness: 0xFF unsigned = 255 -> 1020; signed = -1 -> -4.
        beat(1, 1, 0, 32'hFFFFFFFF, 32'h01010101, 1020, 0);
        beat(1, 1, 1, 32'hFFFFFFFF, 32'h01010101, -4, 0);
        idle(6);

        // Three-beat group with bubbles: 10 + (-5) + 7 = 12.
        beat(1, 0, 1, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h01010101, 0, 0);
        idle(2);
        beat(0, 0, 1, {8'd0, 8'd0, 8'd0, 8'hFB}, 32'h01010101, 0, 0);
        idle(2);
        beat(0, 1, 1, {8'd0, 8'd0, 8'd0, 8'd7}, 32'h01010101, 12, 0);
        idle(6);

        // Back-to-back: lanes = i-3, weights {1,2,3,-1} -> sum 5*(i-3).
        for (int i = 0; i < 8; i++) begin
            lane_b = 8'(i - 3);
            bb_dat = {lane_b, lane_b, lane_b, lane_b};
            beat(1, 1, 1, bb_dat, {8'hFF, 8'd3, 8'd2, 8'd1}, 5 * (i - 3), 0);
        end
        idle(6);

        // First while a group is open discards it: only 7 comes out.
        beat(1, 0, 1, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h01010101, 0, 0);
        beat(1, 1, 1, {8'd0, 8'd0, 8'd0, 8'd7}, 32'h01010101, 7, 0);
        idle(6);

        // Reset mid-group: beats of 100 and 50 lost; stray non-first gives 9.
        beat(1, 0, 1, {8'd25, 8'd25, 8'd25, 8'd25}, 32'h01010101, 0, 0);
        beat(0, 0, 1, {8'd0, 8'd0, 8'd0, 8'd50}, 32'h01010101, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_async_dat", int'(o_dat), 0);
        tick();
        rst = 1'b0;
        idle(1);
        beat(0, 1, 1, {8'd0, 8'd0, 8'd0, 8'd9}, 32'h01010101, 9, 0);
        idle(10);

        chk("pending", exp_cyc.size(), 0);
        chk("hold_vld", int'(o_vld), 0);
        chk("hold_dat", int'($signed(o_dat)), 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
